// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and constants for the BNN accelerator
// Purpose: state encoding and image geometry shared by the sequencer and
// every layer datapath.
// Contents: IMG_DIM, NUM_FILTERS, ADDR_W, state_t.
package bnn_pkg;

  localparam int IMG_DIM     = 28;
  localparam int NUM_FILTERS = 8;
  localparam int ADDR_W      = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LAYER_1 = 3'd2,
    LAYER_2 = 3'd3,
    LAYER_3 = 3'd4
  } state_t;

endpackage

// File: rtl/bnn_sequencer_if.sv
// rtl/bnn_sequencer_if.sv - pixel load and result handshake bundle
// Purpose: groups the serial pixel stream, image-buffer write port and the
// result handshake of the sequencer.
// Signals: pix_valid/pix_ready (pixel strobe), pix_wr_en/pix_row/pix_col
// (image buffer write), result/result_valid/result_ack (classification).
// Modports: master = sequencer side, slave = environment side.
interface bnn_sequencer_if;
  import bnn_pkg::*;

  logic              pix_valid;
  logic              pix_ready;
  logic              pix_wr_en;
  logic [ADDR_W-1:0] pix_row;
  logic [ADDR_W-1:0] pix_col;
  logic [3:0]        result;
  logic              result_valid;
  logic              result_ack;

  modport master (
    input  pix_valid, result_ack,
    output pix_ready, pix_wr_en, pix_row, pix_col, result, result_valid
  );

  modport slave (
    output pix_valid, result_ack,
    input  pix_ready, pix_wr_en, pix_row, pix_col, result, result_valid
  );

endinterface

// File: rtl/bnn_load_addr.sv
// rtl/bnn_load_addr.sv - row/column address counter for the image load
// Purpose: walks the image buffer column-first, wrapping the column at
// IMG_DIM-1 and then advancing the row.
// Ports: clk, rst_n (sync, active-low), clr (back to (0,0)), inc (advance),
// row/col (current address), last (address is (IMG_DIM-1, IMG_DIM-1)).
module bnn_load_addr
  import bnn_pkg::ADDR_W;
#(
  parameter int IMG_DIM = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(IMG_DIM - 1);

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (inc) begin
      if (r_col == MAX_IDX) begin
        r_col <= '0;
        r_row <= (r_row == MAX_IDX) ? '0 : r_row + ADDR_W'(1);
      end else begin
        r_col <= r_col + ADDR_W'(1);
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

endmodule

// File: rtl/bnn_sequencer.sv
// rtl/bnn_sequencer.sv - frame sequencer for the three-layer BNN
// Purpose: loads one IMG_DIM x IMG_DIM image, then steps the layer datapaths
// LAYER_1..LAYER_3, captures the class and guards each layer with a watchdog.
// Ports: clk, rst_n (sync, active-low), start, abort, state (to layers),
// layer_rst_n (first-cycle clear to layers), l1/l2/l3_done (sticky flags),
// class_in, busy, error, bus (pixel stream, buffer write, result handshake).
module bnn_sequencer
  import bnn_pkg::state_t, bnn_pkg::IDLE, bnn_pkg::LOAD,
         bnn_pkg::LAYER_1, bnn_pkg::LAYER_2, bnn_pkg::LAYER_3;
#(
  parameter int IMG_DIM = bnn_pkg::IMG_DIM,
  parameter int TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output state_t                 state,
  output logic                   layer_rst_n,
  input  logic                   l1_done,
  input  logic                   l2_done,
  input  logic                   l3_done,
  input  logic [3:0]             class_in,
  output logic                   busy,
  output logic                   error,
  bnn_sequencer_if.master        bus
);

  // Last watchdog value at which the layer still gets a chance to finish;
  // this bounds the stay in any layer state to exactly TIMEOUT cycles.
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_layer_rst_n;
  logic        r_error;
  logic        r_result_valid;
  logic [3:0]  r_result;
  logic [11:0] r_wdog;

  logic        w_clr;
  logic        w_inc;
  logic        w_last;
  logic        w_first;
  logic        w_done;
  logic        w_timeout;
  logic [4:0]  w_row;
  logic [4:0]  w_col;

  assign w_clr = (r_state == IDLE) && start;
  assign w_inc = (r_state == LOAD) && bus.pix_valid;

  bnn_load_addr #(.IMG_DIM(IMG_DIM)) u_load_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_inc),
    .row   (w_row),
    .col   (w_col),
    .last  (w_last)
  );

  // layer_rst_n is low only in the entry cycle of a layer, so it doubles as
  // the "first cycle" marker used to drop a stale done from the last frame.
  assign w_first = !r_layer_rst_n;

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      LAYER_1: w_done = l1_done;
      LAYER_2: w_done = l2_done;
      LAYER_3: w_done = l3_done;
      default: w_done = 1'b0;
    endcase
    w_done = w_done && !w_first;
  end

  assign w_timeout = (r_wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_layer_rst_n  <= 1'b0;
      r_error        <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= 4'd0;
      r_wdog         <= 12'd0;
    end else begin
      r_layer_rst_n <= 1'b1;
      if (bus.result_ack) begin
        r_result_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state        <= LOAD;
            r_error        <= 1'b0;
            r_result_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (w_inc && w_last) begin
            r_state       <= LAYER_1;
            r_layer_rst_n <= 1'b0;
            r_wdog        <= 12'd0;
          end
        end
        LAYER_1, LAYER_2, LAYER_3: begin
          r_wdog <= r_wdog + 12'd1;
          if (abort) begin
            r_state <= IDLE;
          end else if (w_done) begin
            if (r_state == LAYER_3) begin
              // A capture overrides an ack seen on the same edge.
              r_result       <= class_in;
              r_result_valid <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_state       <= (r_state == LAYER_1) ? LAYER_2 : LAYER_3;
              r_layer_rst_n <= 1'b0;
              r_wdog        <= 12'd0;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state            = r_state;
  assign layer_rst_n      = r_layer_rst_n;
  assign busy             = (r_state != IDLE);
  assign error            = r_error;
  assign bus.pix_ready    = (r_state == LOAD);
  assign bus.pix_wr_en    = rst_n && w_inc;
  assign bus.pix_row      = w_row;
  assign bus.pix_col      = w_col;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_bnn_sequencer.sv
// tb/tb_bnn_sequencer.sv - directed self-checking bench for bnn_sequencer
// Purpose: drives frames through load and the three layers and checks
// sequencing, handshakes, watchdog, abort and reset behaviour.
module tb_bnn_sequencer;
  import bnn_pkg::*;

  localparam int NPIX = IMG_DIM * IMG_DIM;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       l1_done;
  logic       l2_done;
  logic       l3_done;
  logic [3:0] class_in;
  state_t     state;
  logic       layer_rst_n;
  logic       busy;
  logic       error;

  int n_pass  = 0;
  int n_total = 0;

  bnn_sequencer_if bus();

  bnn_sequencer #(.IMG_DIM(IMG_DIM), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .state       (state),
    .layer_rst_n (layer_rst_n),
    .l1_done     (l1_done),
    .l2_done     (l2_done),
    .l3_done     (l3_done),
    .class_in    (class_in),
    .busy        (busy),
    .error       (error),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b1;
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic finish_layer(input int which, input int delay);
    repeat (delay) tick();
    l1_done = (which == 1);
    l2_done = (which == 2);
    l3_done = (which == 3);
    tick();
    l1_done = 1'b0;
    l2_done = 1'b0;
    l3_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pix_valid = 1'b1;
    repeat (2) tick();
    n_total++; if (state !== IDLE) $display("FAIL rst_state: got %0d want %0d", state, IDLE); else n_pass++;
    n_total++; if (bus.pix_row !== 5'd0 || bus.pix_col !== 5'd0) $display("FAIL rst_addr: got (%0d,%0d) want (0,0)", bus.pix_row, bus.pix_col); else n_pass++;
    n_total++; if (layer_rst_n !== 1'b0) $display("FAIL rst_layer_rst_n: got %b want 0", layer_rst_n); else n_pass++;
    n_total++; if (bus.result !== 4'd0 || bus.result_valid !== 1'b0) $display("FAIL rst_result: got %0d/%b want 0/0", bus.result, bus.result_valid); else n_pass++;
    n_total++; if (error !== 1'b0 || busy !== 1'b0) $display("FAIL rst_err_busy: got %b/%b want 0/0", error, busy); else n_pass++;
    n_total++; if (bus.pix_wr_en !== 1'b0 || bus.pix_ready !== 1'b0) $display("FAIL rst_pix: got wr=%b rdy=%b want 0/0", bus.pix_wr_en, bus.pix_ready); else n_pass++;
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_total++; if (layer_rst_n !== 1'b1) $display("FAIL post_rst_layer_rst_n: got %b want 1", layer_rst_n); else n_pass++;
  endtask

  task automatic test_nominal();
    int low_cnt = 0;
    int cyc = 0;
    int in_cnt = 0;
    state_t prev;
    class_in = 4'd7;
    start_frame();
    n_total++; if (state !== LOAD || bus.pix_ready !== 1'b1 || busy !== 1'b1) $display("FAIL nom_load: got st=%0d rdy=%b busy=%b want 1/1/1", state, bus.pix_ready, busy); else n_pass++;
    n_total++; if (bus.pix_row !== 5'd0 || bus.pix_col !== 5'd0) $display("FAIL nom_addr0: got (%0d,%0d) want (0,0)", bus.pix_row, bus.pix_col); else n_pass++;
    bus.pix_valid = 1'b1;
    #1;
    n_total++; if (bus.pix_wr_en !== 1'b1) $display("FAIL nom_wr_en: got %b want 1", bus.pix_wr_en); else n_pass++;
    load_n(NPIX);
    n_total++; if (state !== LAYER_1 || layer_rst_n !== 1'b0 || bus.pix_ready !== 1'b0) $display("FAIL nom_l1_entry: got st=%0d lrst=%b rdy=%b want %0d/0/0", state, layer_rst_n, bus.pix_ready, LAYER_1); else n_pass++;
    prev = state;
    while (state != IDLE && cyc < 200) begin
      if (state != prev) in_cnt = 0;
      prev = state;
      if (layer_rst_n == 1'b0) low_cnt++;
      l1_done = (state == LAYER_1) && (in_cnt == 10);
      l2_done = (state == LAYER_2) && (in_cnt == 10);
      l3_done = (state == LAYER_3) && (in_cnt == 10);
      tick();
      in_cnt++;
      cyc++;
    end
    l1_done = 1'b0;
    l2_done = 1'b0;
    l3_done = 1'b0;
    n_total++; if (cyc !== 33) $display("FAIL nom_layer_cycles: got %0d want 33", cyc); else n_pass++;
    n_total++; if (state !== IDLE || busy !== 1'b0) $display("FAIL nom_idle: got st=%0d busy=%b want 0/0", state, busy); else n_pass++;
    n_total++; if (bus.result !== 4'd7 || bus.result_valid !== 1'b1) $display("FAIL nom_result: got %0d/%b want 7/1", bus.result, bus.result_valid); else n_pass++;
    n_total++; if (low_cnt !== 3) $display("FAIL nom_layer_rst_low: got %0d want 3", low_cnt); else n_pass++;
    n_total++; if (error !== 1'b0 || layer_rst_n !== 1'b1) $display("FAIL nom_err_lrst: got %b/%b want 0/1", error, layer_rst_n); else n_pass++;
  endtask

  task automatic test_result_ack();
    repeat (3) tick();
    n_total++; if (bus.result_valid !== 1'b1) $display("FAIL ack_hold: got %b want 1", bus.result_valid); else n_pass++;
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    n_total++; if (bus.result_valid !== 1'b0 || bus.result !== 4'd7) $display("FAIL ack_clear: got %b/%0d want 0/7", bus.result_valid, bus.result); else n_pass++;
  endtask

  task automatic test_stall();
    class_in = 4'd2;
    start_frame();
    load_n(28);
    n_total++; if (bus.pix_row !== 5'd1 || bus.pix_col !== 5'd0) $display("FAIL stall_wrap: got (%0d,%0d) want (1,0)", bus.pix_row, bus.pix_col); else n_pass++;
    repeat (5) tick();
    n_total++; if (bus.pix_row !== 5'd1 || bus.pix_col !== 5'd0 || state !== LOAD) $display("FAIL stall_hold: got (%0d,%0d) st=%0d want (1,0) st=1", bus.pix_row, bus.pix_col, state); else n_pass++;
    n_total++; if (bus.pix_wr_en !== 1'b0) $display("FAIL stall_wr_en: got %b want 0", bus.pix_wr_en); else n_pass++;
    load_n(NPIX - 29);
    bus.pix_valid = 1'b1;
    #1;
    n_total++; if (bus.pix_wr_en !== 1'b1 || bus.pix_row !== 5'd27 || bus.pix_col !== 5'd27) $display("FAIL stall_last_write: got wr=%b (%0d,%0d) want 1 (27,27)", bus.pix_wr_en, bus.pix_row, bus.pix_col); else n_pass++;
    n_total++; if (state !== LOAD) $display("FAIL stall_still_load: got %0d want 1", state); else n_pass++;
    tick();
    bus.pix_valid = 1'b0;
    n_total++; if (state !== LAYER_1) $display("FAIL stall_l1: got %0d want %0d", state, LAYER_1); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if (state !== IDLE || bus.result_valid !== 1'b0 || error !== 1'b0 || bus.result !== 4'd7) $display("FAIL abort_l1: got st=%0d rv=%b err=%b res=%0d want 0/0/0/7", state, bus.result_valid, error, bus.result); else n_pass++;
  endtask

  task automatic test_stale_done();
    start_frame();
    load_n(NPIX - 1);
    bus.pix_valid = 1'b1;
    l1_done = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    n_total++; if (state !== LAYER_1 || layer_rst_n !== 1'b0) $display("FAIL stale_entry: got st=%0d lrst=%b want %0d/0", state, layer_rst_n, LAYER_1); else n_pass++;
    tick();
    l1_done = 1'b0;
    n_total++; if (state !== LAYER_1 || layer_rst_n !== 1'b1) $display("FAIL stale_ignored: got st=%0d lrst=%b want %0d/1", state, layer_rst_n, LAYER_1); else n_pass++;
    tick();
    n_total++; if (state !== LAYER_1) $display("FAIL stale_wait: got %0d want %0d", state, LAYER_1); else n_pass++;
    l1_done = 1'b1;
    tick();
    l1_done = 1'b0;
    n_total++; if (state !== LAYER_2 || layer_rst_n !== 1'b0) $display("FAIL stale_advance: got st=%0d lrst=%b want %0d/0", state, layer_rst_n, LAYER_2); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_timeout();
    int c = 0;
    start_frame();
    load_n(NPIX);
    finish_layer(1, 3);
    n_total++; if (state !== LAYER_2) $display("FAIL to_l2: got %0d want %0d", state, LAYER_2); else n_pass++;
    while (state == LAYER_2 && c < 40) begin
      tick();
      c++;
    end
    n_total++; if (c !== 16) $display("FAIL to_cycles: got %0d want 16", c); else n_pass++;
    n_total++; if (state !== IDLE || error !== 1'b1 || bus.result_valid !== 1'b0) $display("FAIL to_outcome: got st=%0d err=%b rv=%b want 0/1/0", state, error, bus.result_valid); else n_pass++;
    repeat (3) tick();
    n_total++; if (error !== 1'b1) $display("FAIL to_sticky: got %b want 1", error); else n_pass++;
    start_frame();
    n_total++; if (error !== 1'b0 || state !== LOAD) $display("FAIL to_start_clears: got err=%b st=%0d want 0/1", error, state); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort_l3();
    class_in = 4'd9;
    start_frame();
    load_n(NPIX);
    finish_layer(1, 2);
    finish_layer(2, 2);
    n_total++; if (state !== LAYER_3) $display("FAIL ab3_reach: got %0d want %0d", state, LAYER_3); else n_pass++;
    repeat (4) tick();
    l3_done = 1'b1;
    abort = 1'b1;
    tick();
    l3_done = 1'b0;
    abort = 1'b0;
    n_total++; if (state !== IDLE || bus.result_valid !== 1'b0 || error !== 1'b0) $display("FAIL ab3_outcome: got st=%0d rv=%b err=%b want 0/0/0", state, bus.result_valid, error); else n_pass++;
    n_total++; if (bus.result !== 4'd7) $display("FAIL ab3_result_held: got %0d want 7", bus.result); else n_pass++;
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (state !== LOAD) $display("FAIL abst_start_wins: got %0d want 1", state); else n_pass++;
    tick();
    abort = 1'b0;
    n_total++; if (state !== IDLE) $display("FAIL abst_abort_load: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_reset_mid();
    class_in = 4'd4;
    start_frame();
    load_n(400);
    n_total++; if (bus.pix_row !== 5'd14 || bus.pix_col !== 5'd8) $display("FAIL mid_addr400: got (%0d,%0d) want (14,8)", bus.pix_row, bus.pix_col); else n_pass++;
    bus.pix_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    n_total++; if (state !== IDLE || busy !== 1'b0 || layer_rst_n !== 1'b0) $display("FAIL mid_rst_state: got st=%0d busy=%b lrst=%b want 0/0/0", state, busy, layer_rst_n); else n_pass++;
    n_total++; if (bus.pix_row !== 5'd0 || bus.pix_col !== 5'd0 || bus.pix_wr_en !== 1'b0) $display("FAIL mid_rst_addr: got (%0d,%0d) wr=%b want (0,0) 0", bus.pix_row, bus.pix_col, bus.pix_wr_en); else n_pass++;
    n_total++; if (bus.result !== 4'd0 || bus.result_valid !== 1'b0 || error !== 1'b0) $display("FAIL mid_rst_result: got %0d/%b err=%b want 0/0/0", bus.result, bus.result_valid, error); else n_pass++;
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    class_in = 4'd11;
    start_frame();
    load_n(NPIX);
    finish_layer(1, 10);
    finish_layer(2, 10);
    finish_layer(3, 10);
    n_total++; if (state !== IDLE || bus.result !== 4'd11 || bus.result_valid !== 1'b1) $display("FAIL mid_next_frame: got st=%0d res=%0d rv=%b want 0/11/1", state, bus.result, bus.result_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    class_in = 4'd3;
    start_frame();
    n_total++; if (bus.result_valid !== 1'b0 || bus.result !== 4'd11) $display("FAIL b2b_start_clears_rv: got rv=%b res=%0d want 0/11", bus.result_valid, bus.result); else n_pass++;
    load_n(NPIX);
    finish_layer(1, 1);
    finish_layer(2, 1);
    finish_layer(3, 1);
    n_total++; if (bus.result !== 4'd3 || bus.result_valid !== 1'b1) $display("FAIL b2b_first: got %0d/%b want 3/1", bus.result, bus.result_valid); else n_pass++;
    class_in = 4'd15;
    start_frame();
    load_n(NPIX);
    finish_layer(1, 5);
    finish_layer(2, 5);
    finish_layer(3, 5);
    n_total++; if (bus.result !== 4'd15 || bus.result_valid !== 1'b1 || state !== IDLE) $display("FAIL b2b_second: got %0d/%b st=%0d want 15/1/0", bus.result, bus.result_valid, state); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    l3_done = 1'b0;
    class_in = 4'd0;
    bus.pix_valid = 1'b0;
    bus.result_ack = 1'b0;
    test_reset();
    test_nominal();
    test_result_ack();
    test_stall();
    test_stale_done();
    test_timeout();
    test_abort_l3();
    test_abort_start_idle();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule

// File: doc/bnn_sequencer.md
BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 SHALL have parameter IMG_DIM, default 28, image side length in pixels.
REQ-002 SHALL have parameter TIMEOUT, default 4095, maximum number of cycles allowed in any layer state.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a new frame.
REQ-006 SHALL have port abort  input  1  cancel the frame in progress.
REQ-007 SHALL have port pix_valid  input  1  serial pixel strobe.
REQ-008 SHALL have port pix_ready  output  1  high only in LOAD.
REQ-009 SHALL have port pix_wr_en  output  1  image buffer write enable.
REQ-010 SHALL have ports pix_row, pix_col  output  5 each  image buffer write address.
REQ-011 SHALL have port state  output  state_t  drives the layer datapaths.
REQ-012 SHALL have port layer_rst_n  output  1  synchronous active-low clear to the layer datapaths.
REQ-013 SHALL have ports l1_done, l2_done, l3_done  input  1 each  sticky layer-complete flags.
REQ-014 SHALL have port class_in  input  4  layer-3 classification.
REQ-015 SHALL have ports result  output  4, result_valid  output  1, result_ack  input  1.
REQ-016 SHALL have ports busy  output  1 and error  output  1.

Function
REQ-017 SHALL implement the state sequence IDLE -> LOAD -> LAYER_1 -> LAYER_2 -> LAYER_3 -> IDLE, using the state_t encodings 0..4.
REQ-018 In IDLE, start SHALL cause entry to LOAD on the next cycle, clear the load address to (0,0), and clear error and result_valid; start SHALL be ignored outside IDLE.
REQ-019 In LOAD, pix_wr_en SHALL equal pix_valid combinationally, with pix_row/pix_col giving the current address.
REQ-020 The load address SHALL advance column-first and wrap the column at IDLE_DIM-1... corrected: wrap the column at IMG_DIM-1 and increment the row.
REQ-021 Acceptance of pixel (IMG_DIM-1, IMG_DIM-1) SHALL enter LAYER_1 on the next cycle; gaps in pix_valid SHALL stall the load without limit.
REQ-022 layer_rst_n SHALL be a registered output that is 0 during exactly the first cycle of each LAYER_n state and 1 otherwise.
REQ-023 ln_done SHALL be ignored during the first cycle of LAYER_n, so that a stale flag from the previous frame is discarded.
REQ-024 ln_done SHALL be ignored when the state is not LAYER_n.
REQ-025 On l1_done or l2_done, the block SHALL advance to the next layer on the next cycle.
REQ-026 On l3_done, the block SHALL register result <= class_in, set result_valid, and enter IDLE, all on the same edge.
REQ-027 result_valid SHALL hold until the cycle after result_ack or a new accepted start; result SHALL hold its value until the next capture.
REQ-028 A watchdog counter (12 bits) SHALL clear on each layer entry and increment every cycle in LAYER_n.
REQ-029 When the watchdog reaches TIMEOUT without ln_done, the block SHALL set error (sticky until the next start), enter IDLE, and leave result_valid unchanged.
REQ-030 abort SHALL force IDLE on the next cycle from any non-IDLE state, with priority over done, timeout and load completion; no result SHALL be produced, and error SHALL be unchanged.
REQ-031 When abort and start are high in IDLE, start SHALL be taken.
REQ-032 busy SHALL equal (state != IDLE); pix_ready SHALL equal (state == LOAD).

Reset
REQ-033 While rst_n=0 at a clock edge, the following SHALL be forced: state=IDLE, load address (0,0), watchdog 0, layer_rst_n=0, result=0, result_valid=0, error=0, pix_wr_en=0.
REQ-034 Reset mid-frame SHALL discard all progress; the first frame after reset SHALL behave identically to any other frame.

Structure
REQ-035 state_t, IMG_DIM and NUM_FILTERS (8) SHALL live in shared package bnn_pkg, imported by this block and by every layer.
REQ-036 The load address counter SHALL be the single sub-module bnn_load_addr (inputs clr, inc; outputs row, col, last); the FSM and watchdog SHALL stay inline.

Verification
REQ-037 Nominal frame: start, then 784 consecutive pix_valid, l1/l2/l3_done each 10 cycles after entry, class_in=7 -> result=7, result_valid=1, state returns to IDLE, layer_rst_n low exactly 3 cycles.
REQ-038 Stalled load: pix_valid low for 5 cycles after pixel 27 -> address holds at (1,0), then completes; the final write goes to (27,27) and LAYER_1 is entered on the next cycle.
REQ-039 Stale done: l1_done held high from the previous frame on the LAYER_1 entry cycle -> no advance in that cycle; advance occurs only on a later done.
REQ-040 Timeout with TIMEOUT=16 and l2_done never asserted -> error=1 after 16 cycles in LAYER_2, then IDLE with result_valid=0; the next start clears error.
REQ-041 Abort during LAYER_3 in the same cycle as l3_done -> IDLE, result_valid stays 0, error stays 0.
REQ-042 rst_n pulsed low at pixel 400 -> all outputs take their REQ-033 values; a subsequent full frame produces the correct result.
